// File: rtl/demux_stream_pkg.sv
// Shared types and helpers for the 1-to-N stream demultiplexer.
package demux_stream_pkg;

    // Largest channel count the demux is built and checked for.
    localparam int MAX_N_OUT = 16;

    // Occupancy of a single output holding register.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Select width for n channels; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output holding register with valid/ready drain and a free flag.
module demux_out_slot
    import demux_stream_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              free_o
);

    slot_state_e       state_q;
    slot_state_e       state_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    // Next state: a load always wins, a drain without load empties the slot.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        case (state_q)
            SLOT_EMPTY: begin
                if (load_i) begin
                    state_d = SLOT_FULL;
                end else begin
                    state_d = SLOT_EMPTY;
                end
            end
            SLOT_FULL: begin
                if (load_i) begin
                    state_d = SLOT_FULL;
                end else if (ready_i) begin
                    state_d = SLOT_EMPTY;
                end else begin
                    state_d = SLOT_FULL;
                end
            end
            default: begin
                state_d = SLOT_EMPTY;
            end
        endcase
        if (load_i) begin
            data_d = data_i;
        end else begin
            data_d = data_q;
        end
    end

    // Slot state and payload registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            data_q  <= {DATA_W{1'b0}};
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = (state_q == SLOT_FULL);
    assign data_o  = data_q;
    // Free when empty, or when the held beat leaves this cycle.
    assign free_o  = (state_q == SLOT_EMPTY) | ready_i;

endmodule

// File: rtl/demux_stream_n.sv
// Registered 1-to-N valid/ready demultiplexer with broadcast and drop counter.
module demux_stream_n
    import demux_stream_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int N_OUT  = 4,
    parameter  int CNT_W  = 16,
    localparam int SEL_W  = sel_width(N_OUT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_bcast,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ready,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic                    drop_pulse,
    output logic [CNT_W-1:0]        drop_cnt
);

    localparam logic [SEL_W:0]   N_OUT_V = (SEL_W + 1)'(N_OUT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W - 1){1'b0}}, 1'b1};

    if ((N_OUT < 2) || (N_OUT > MAX_N_OUT)) begin : g_bad_n_out
        $error("demux_stream_n: N_OUT out of range");
    end

    logic [N_OUT-1:0] free_s;
    logic [N_OUT-1:0] load_s;
    logic             all_free_s;
    logic             sel_free_s;
    logic             sel_legal_s;
    logic             accept_s;
    logic             drop_s;
    logic             drop_pulse_q;
    logic             drop_pulse_d;
    logic [CNT_W-1:0] drop_cnt_q;
    logic [CNT_W-1:0] drop_cnt_d;

    // Non-power-of-two channel counts leave select codes with no channel.
    assign sel_legal_s = ({1'b0, in_sel} < N_OUT_V);

    // Ready, accept and per-slot load decode; in_valid never feeds in_ready.
    always_comb begin
        all_free_s = &free_s;
        sel_free_s = 1'b0;
        load_s     = {N_OUT{1'b0}};
        for (int k = 0; k < N_OUT; k++) begin
            sel_free_s = sel_free_s | (free_s[k] & (in_sel == SEL_W'(k)));
        end
        if (in_bcast) begin
            in_ready = all_free_s;
        end else if (sel_legal_s) begin
            in_ready = sel_free_s;
        end else begin
            in_ready = 1'b1;
        end
        accept_s = in_valid & in_ready;
        for (int k = 0; k < N_OUT; k++) begin
            load_s[k] = accept_s & (in_bcast | (in_sel == SEL_W'(k)));
        end
        drop_s = accept_s & ~in_bcast & ~sel_legal_s;
    end

    // Drop pulse follows an accepted illegal beat; counter holds at all-ones.
    always_comb begin
        drop_pulse_d = drop_s;
        if (drop_s && (drop_cnt_q != CNT_MAX)) begin
            drop_cnt_d = drop_cnt_q + CNT_ONE;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Drop status registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_pulse_q <= 1'b0;
            drop_cnt_q   <= {CNT_W{1'b0}};
        end else begin
            drop_pulse_q <= drop_pulse_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign drop_pulse = drop_pulse_q;
    assign drop_cnt   = drop_cnt_q;

    for (genvar g = 0; g < N_OUT; g++) begin : g_slot
        demux_out_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .load_i  (load_s[g]),
            .data_i  (in_data),
            .ready_i (out_ready[g]),
            .valid_o (out_valid[g]),
            .data_o  (out_data[g*DATA_W +: DATA_W]),
            .free_o  (free_s[g])
        );
    end

endmodule

// File: tb/tb_demux_stream_n.sv
// Self-checking bench: four demux configurations driven one at a time,
// checked against a per-channel expected-data queue model.
module tb_demux_stream_n;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_c;
    logic [7:0]  in_data_c;
    logic [3:0]  sel_c;
    logic        bcast_c;
    logic [15:0] ordy_c;
    int          cur;

    always #5 clk = ~clk;

    // cfg0: N=4 CNT=16, cfg1: N=5 CNT=4, cfg2: N=2 CNT=16, cfg3: N=16 CNT=16
    logic ir0, dp0, ir1, dp1, ir2, dp2, ir3, dp3;
    logic [3:0]   ov0;
    logic [4:0]   ov1;
    logic [1:0]   ov2;
    logic [15:0]  ov3;
    logic [31:0]  od0;
    logic [39:0]  od1;
    logic [15:0]  od2;
    logic [127:0] od3;
    logic [15:0]  dc0, dc2, dc3;
    logic [3:0]   dc1;

    demux_stream_n #(.DATA_W(8), .N_OUT(4), .CNT_W(16)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid_c && (cur == 0)), .in_ready(ir0),
        .in_data(in_data_c), .in_sel(sel_c[1:0]), .in_bcast(bcast_c),
        .out_valid(ov0), .out_ready(ordy_c[3:0]), .out_data(od0),
        .drop_pulse(dp0), .drop_cnt(dc0));

    demux_stream_n #(.DATA_W(8), .N_OUT(5), .CNT_W(4)) u_dut5 (
        .clk(clk), .rst(rst), .in_valid(in_valid_c && (cur == 1)), .in_ready(ir1),
        .in_data(in_data_c), .in_sel(sel_c[2:0]), .in_bcast(bcast_c),
        .out_valid(ov1), .out_ready(ordy_c[4:0]), .out_data(od1),
        .drop_pulse(dp1), .drop_cnt(dc1));

    demux_stream_n #(.DATA_W(8), .N_OUT(2), .CNT_W(16)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid_c && (cur == 2)), .in_ready(ir2),
        .in_data(in_data_c), .in_sel(sel_c[0:0]), .in_bcast(bcast_c),
        .out_valid(ov2), .out_ready(ordy_c[1:0]), .out_data(od2),
        .drop_pulse(dp2), .drop_cnt(dc2));

    demux_stream_n #(.DATA_W(8), .N_OUT(16), .CNT_W(16)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid_c && (cur == 3)), .in_ready(ir3),
        .in_data(in_data_c), .in_sel(sel_c), .in_bcast(bcast_c),
        .out_valid(ov3), .out_ready(ordy_c), .out_data(od3),
        .drop_pulse(dp3), .drop_cnt(dc3));

    // View of the configuration under test, zero-extended to the widest case.
    logic         ir_c, dp_c;
    logic [15:0]  ov_c, dc_c;
    logic [127:0] od_c;

    // Select the outputs of the active configuration.
    always_comb begin
        ir_c = 1'b0; dp_c = 1'b0; ov_c = 16'h0; dc_c = 16'h0; od_c = 128'h0;
        case (cur)
            0: begin ir_c = ir0; dp_c = dp0; ov_c = {12'h0, ov0}; dc_c = dc0; od_c = {96'h0, od0}; end
            1: begin ir_c = ir1; dp_c = dp1; ov_c = {11'h0, ov1}; dc_c = {12'h0, dc1}; od_c = {88'h0, od1}; end
            2: begin ir_c = ir2; dp_c = dp2; ov_c = {14'h0, ov2}; dc_c = dc2; od_c = {112'h0, od2}; end
            3: begin ir_c = ir3; dp_c = dp3; ov_c = ov3; dc_c = dc3; od_c = od3; end
            default: begin ir_c = 1'b0; end
        endcase
    end

    function automatic int nch(input int c);
        case (c)
            0: return 4;
            1: return 5;
            2: return 2;
            default: return 16;
        endcase
    endfunction

    function automatic int cntmax(input int c);
        return (c == 1) ? 15 : 65535;
    endfunction

    function automatic int selmax(input int c);
        return (c == 1) ? 7 : nch(c) - 1;
    endfunction

    // Scoreboard state
    logic [7:0] exp_q [16][$];
    int         n_checks = 0;
    int         n_errs   = 0;
    logic       exp_dp   = 1'b0;
    int         mcnt     = 0;
    logic       last_acc = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // Compare the current cycle against the model, then advance the model.
    task automatic model_cycle();
        int          n;
        logic        exp_ir;
        logic        all_free;
        logic [15:0] fr;
        n = nch(cur);
        fr = 16'h0;
        check("drop_pulse", 32'(dp_c), 32'(exp_dp));
        check("drop_cnt", 32'(dc_c), mcnt);
        for (int k = 0; k < n; k++) begin
            check("out_valid", 32'(ov_c[k]), 32'(exp_q[k].size() != 0));
        end
        last_acc = 1'b0;
        if (rst) begin
            for (int k = 0; k < 16; k++) exp_q[k].delete();
            exp_dp = 1'b0;
            mcnt = 0;
        end else begin
            all_free = 1'b1;
            for (int k = 0; k < n; k++) begin
                fr[k] = (exp_q[k].size() == 0) || ordy_c[k];
                all_free = all_free & fr[k];
            end
            if (bcast_c) exp_ir = all_free;
            else if (int'(sel_c) < n) exp_ir = fr[sel_c];
            else exp_ir = 1'b1;
            check("in_ready", 32'(ir_c), 32'(exp_ir));
            for (int k = 0; k < n; k++) begin
                if (ordy_c[k] && (exp_q[k].size() != 0)) begin
                    check("out_data", 32'(od_c[k*8 +: 8]), 32'(exp_q[k].pop_front()));
                end
            end
            exp_dp = 1'b0;
            if (in_valid_c && exp_ir) begin
                last_acc = 1'b1;
                if (bcast_c) begin
                    for (int k = 0; k < n; k++) exp_q[k].push_back(in_data_c);
                end else if (int'(sel_c) < n) begin
                    exp_q[sel_c].push_back(in_data_c);
                end else begin
                    exp_dp = 1'b1;
                    if (mcnt < cntmax(cur)) mcnt++;
                end
            end
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] s, input logic b,
                         input logic [7:0] d, input logic [15:0] r);
        in_valid_c = v; sel_c = s; bcast_c = b; in_data_c = d; ordy_c = r;
    endtask

    task automatic half();
        @(negedge clk);
        model_cycle();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        half();
        adv();
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        in_valid_c = 1'b0;
        repeat (cycles) step();
        rst = 1'b0;
    endtask

    // Producer rule: sel/bcast hold while a beat waits for in_ready.
    logic       prev_stall = 1'b0;
    logic [3:0] prev_sel   = 4'h0;
    logic       prev_bc    = 1'b0;
    always @(negedge clk) begin
        if (prev_stall && !rst) begin
            assert (sel_c == prev_sel && bcast_c == prev_bc)
                else $error("producer changed sel/bcast while stalled");
        end
        prev_stall <= in_valid_c && !ir_c && !rst;
        prev_sel   <= sel_c;
        prev_bc    <= bcast_c;
    end

    initial begin
        cur = 0;
        drive(1'b0, 4'h0, 1'b0, 8'h00, 16'hFFFF);
        do_reset(2);

        // Reset state
        half();
        check("rst_ov", 32'(ov_c), 32'h0);
        check("rst_dp", 32'(dp_c), 32'h0);
        check("rst_dc", 32'(dc_c), 32'h0);
        adv();

        // Unicast and back-to-back streaming
        drive(1'b1, 4'd2, 1'b0, 8'hA5, 16'hFFFF);
        half(); check("uc_ready", 32'(ir_c), 32'h1); adv();
        drive(1'b0, 4'd2, 1'b0, 8'h00, 16'hFFFF);
        half(); check("uc_ov", 32'(ov_c), 32'h4); check("uc_data", 32'(od_c[23:16]), 32'hA5); adv();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'd2, 1'b0, 8'(8'h10 + i), 16'hFFFF);
            half();
            check("b2b_ready", 32'(ir_c), 32'h1);
            if (i > 0) check("b2b_data", 32'(od_c[23:16]), 32'(8'h10 + i - 1));
            adv();
        end
        drive(1'b0, 4'd0, 1'b0, 8'h00, 16'hFFFF);
        step();

        // Backpressure on channel 1
        drive(1'b1, 4'd1, 1'b0, 8'h11, 16'hFFFD);
        half(); check("bp_ready1", 32'(ir_c), 32'h1); adv();
        drive(1'b1, 4'd1, 1'b0, 8'h22, 16'hFFFD);
        half(); check("bp_ready2", 32'(ir_c), 32'h0); check("bp_hold", 32'(od_c[15:8]), 32'h11); adv();
        half(); check("bp_stable", 32'(od_c[15:8]), 32'h11); check("bp_ov", 32'(ov_c), 32'h2); adv();
        drive(1'b1, 4'd1, 1'b0, 8'h22, 16'hFFFF);
        half(); check("bp_refill", 32'(ir_c), 32'h1); adv();
        drive(1'b0, 4'd0, 1'b0, 8'h00, 16'hFFFF);
        half(); check("bp_second", 32'(od_c[15:8]), 32'h22); check("bp_ov2", 32'(ov_c), 32'h2); adv();
        step();

        // Broadcast all-or-nothing
        drive(1'b1, 4'd1, 1'b0, 8'h77, 16'hFFFD);
        step();
        drive(1'b1, 4'd0, 1'b1, 8'h3C, 16'hFFFD);
        half(); check("bc_block", 32'(ir_c), 32'h0); check("bc_ov", 32'(ov_c), 32'h2); adv();
        half(); check("bc_ov_hold", 32'(ov_c), 32'h2); adv();
        drive(1'b1, 4'd0, 1'b1, 8'h3C, 16'hFFFF);
        half(); check("bc_ready", 32'(ir_c), 32'h1); adv();
        drive(1'b0, 4'd0, 1'b0, 8'h00, 16'hFFFF);
        half();
        check("bc_all_ov", 32'(ov_c), 32'hF);
        for (int k = 0; k < 4; k++) check("bc_data", 32'(od_c[k*8 +: 8]), 32'h3C);
        adv();
        step();

        // Reset while channels 0 and 3 are full and stalled
        drive(1'b1, 4'd0, 1'b0, 8'hC0, 16'hFFF6);
        step();
        drive(1'b1, 4'd3, 1'b0, 8'hC3, 16'hFFF6);
        step();
        drive(1'b1, 4'd1, 1'b0, 8'h99, 16'hFFF6);
        rst = 1'b1;
        half(); check("pre_rst_ov", 32'(ov_c), 32'h9); adv();
        rst = 1'b0;
        drive(1'b0, 4'd0, 1'b0, 8'h00, 16'hFFF6);
        half(); check("rst_mid_ov", 32'(ov_c), 32'h0); check("rst_mid_dc", 32'(dc_c), 32'h0); adv();
        half(); check("rst_mid_lost", 32'(ov_c), 32'h0); adv();

        // Illegal select and counter saturation (N=5, CNT_W=4)
        in_valid_c = 1'b0;
        cur = 1;
        drive(1'b1, 4'd6, 1'b0, 8'hE6, 16'hFFFF);
        half(); check("il_ready", 32'(ir_c), 32'h1); adv();
        drive(1'b0, 4'd0, 1'b0, 8'h00, 16'hFFFF);
        half();
        check("il_pulse", 32'(dp_c), 32'h1);
        check("il_cnt", 32'(dc_c), 32'h1);
        check("il_ov", 32'(ov_c), 32'h0);
        adv();
        half(); check("il_pulse_end", 32'(dp_c), 32'h0); adv();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 4'(5 + (i % 3)), 1'b0, 8'(i), 16'hFFFF);
            step();
        end
        drive(1'b0, 4'd0, 1'b0, 8'h00, 16'hFFFF);
        step();
        half(); check("sat_cnt", 32'(dc_c), 32'd15); adv();
        do_reset(1);
        half(); check("sat_rst_cnt", 32'(dc_c), 32'h0); adv();

        // Randomised interleaving for N = 2, 16, 5
        for (int c = 0; c < 3; c++) begin
            in_valid_c = 1'b0;
            cur = (c == 0) ? 2 : ((c == 1) ? 3 : 1);
            do_reset(1);
            repeat (400) begin
                if (!(in_valid_c && !last_acc)) begin
                    in_valid_c = ($urandom_range(0, 3) != 0);
                    bcast_c    = ($urandom_range(0, 7) == 0);
                    sel_c      = 4'($urandom_range(0, selmax(cur)));
                    in_data_c  = 8'($urandom);
                end
                ordy_c = 16'($urandom) | 16'($urandom);
                step();
            end
            drive(1'b0, 4'd0, 1'b0, 8'h00, 16'hFFFF);
            repeat (3) step();
            for (int k = 0; k < nch(cur); k++) begin
                check("drain_empty", 32'(exp_q[k].size()), 32'h0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/demux_stream_n.md
Name: demux_stream_n

Overview:
- Parametrised, registered 1-to-N stream demultiplexer.
- Routes one valid/ready input stream to one of N_OUT output channels, or to all of them in broadcast mode.
- Each output channel has a one-entry holding register.
- Successor to the team's fixed 1-to-4 gate-level demux; sits between a single producer and N independent consumers that may stall.

Parameters:
- DATA_W, 8, payload width in bits.
- N_OUT, 4, number of output channels; legal range 2..16.
- SEL_W, clog2(N_OUT) (derived localparam, not overridable), select width.
- CNT_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  producer has a beat.
- in_ready  out  1  block accepts the beat this cycle.
- in_data  in  DATA_W  payload.
- in_sel  in  SEL_W  target channel index.
- in_bcast  in  1  1 = deliver to all channels; in_sel ignored.
- out_valid  out  N_OUT  per-channel valid.
- out_ready  in  N_OUT  per-channel ready.
- out_data  out  N_OUT*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- drop_pulse  out  1  one-cycle pulse: beat accepted with in_sel >= N_OUT and discarded.
- drop_cnt  out  CNT_W  saturating count of dropped beats.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - out_valid=0 on all channels, drop_pulse=0, drop_cnt=0.
  - out_data is don't-care but driven (zeros).
  - Reset overrides any transfer in the same cycle.
  - Beats held at reset time are lost; no handshake completes during the reset cycle.
- Slot free: channel k is free when out_valid[k]=0, or when out_valid[k]=1 and out_ready[k]=1 in this cycle (drain and refill in the same cycle allowed).
- in_ready (combinational from in_sel, in_bcast, slot state, out_ready; independent of in_valid):
  - unicast, in_sel < N_OUT: free[in_sel].
  - unicast, in_sel >= N_OUT: 1 (beat is always accepted and discarded).
  - broadcast: AND of free[k] over all k.
- Accept = in_valid & in_ready. On accept:
  - unicast legal: slot[in_sel] loads in_data; out_valid[in_sel]=1 next cycle.
  - broadcast: every slot loads in_data; all out_valid=1 next cycle.
  - unicast illegal: no slot changes; drop_pulse=1 next cycle; drop_cnt increments and holds at 2^CNT_W-1.
- Latency: exactly 1 cycle from accept to out_valid. Full throughput of 1 beat/cycle when the target consumer holds out_ready=1.
- Output handshake: out_valid[k] & out_ready[k] completes a transfer.
  - If no reload the same cycle, out_valid[k] clears next cycle.
  - While out_valid[k]=1 and out_ready[k]=0, out_data[k] and out_valid[k] are stable.
- Ordering: per-channel order is preserved. There is no ordering guarantee across channels.
- Broadcast with any channel stalled: in_ready=0 and nothing is partially delivered (all-or-nothing).
- in_sel and in_bcast must be stable while in_valid=1 and in_ready=0. The producer guarantees this; the bench asserts it.
- Slot state machine, per channel: EMPTY -> (load) FULL; FULL -> (drain, no load) EMPTY; FULL -> (drain + load) FULL.
- Power-of-two N_OUT: the illegal-select path is unreachable. drop_pulse stays 0 but is still implemented.

Decomposition:
- Package demux_stream_pkg:
  - function sel_width(n), returning clog2 with a minimum of 1.
  - constant MAX_N_OUT=16.
- Sub-module demux_out_slot: one-entry register with load / drain / valid and a free output. Instantiated N_OUT times by a generate loop.
- Top level holds the ready logic, the decode and the drop counter.

Test Plan:
- Reset then unicast: N_OUT=4, all out_ready=1; send 0xA5 sel=2 -> out_valid=0100 one cycle later, out_data[2]=0xA5; in_ready stays 1; back-to-back beats to sel=2 stream at 1/cycle.
- Backpressure: out_ready[1]=0; send 0x11 then 0x22 to sel=1 -> 0x11 held stable, in_ready=0 for the 2nd beat. Raise out_ready[1] -> 0x11 drains, 0x22 is accepted the same cycle, and 0x22 appears next cycle.
- Broadcast all-or-nothing: out_ready=1101, channel 1 full; bcast 0x3C -> in_ready=0, no out_valid changes. Release channel 1 -> all four channels show 0x3C together.
- Illegal select: N_OUT=5 (SEL_W=3); send sel=6 -> in_ready=1, no out_valid, drop_pulse for one cycle, drop_cnt=1. Then CNT_W=4 with 20 drops -> drop_cnt saturates at 15.
- Reset mid-operation: channels 0 and 3 full and stalled, rst=1 for one cycle with in_valid=1 -> out_valid=0000 after reset, beat not delivered, drop_cnt=0.
- Randomised interleaving against a per-channel FIFO scoreboard, N_OUT in {2,5,16} -> no loss, duplication or reordering per channel.
